// File: rtl/float16_dot_seq.sv
// Half-precision dot-product sequencer over N operand pairs, time-sharing
// one external combinational multiplier and one external combinational adder.
//
// Ports:
//   clk, reset (async, active-low), start, clear (sync abort)
//   busy, done            : status; done pulses one cycle when result is valid
//   rd_addr               : registered element index to the operand memory
//   a_data, b_data        : operands, valid the cycle after rd_addr
//   mult_a/mult_b/mult_p  : external floatMult16 interface
//   add_a/add_b/add_s     : external floatAdd16 interface
//   result                : registered dot product, held until overwritten
module float16_dot_seq #(
    parameter int N      = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       a_data,
    input  logic [15:0]       b_data,
    output logic [15:0]       mult_a,
    output logic [15:0]       mult_b,
    input  logic [15:0]       mult_p,
    output logic [15:0]       add_a,
    output logic [15:0]       add_b,
    input  logic [15:0]       add_s,
    output logic [15:0]       result
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MUL,
        ACC,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [15:0]       acc_q;
    logic [15:0]       prod_q;
    logic              last;

    assign last = (idx_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // clear overrides every transition, including start in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = MUL;
            MUL:     state_d = ACC;
            ACC:     state_d = last ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            rd_addr <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            result  <= '0;
        end else if (clear) begin
            idx_q   <= '0;
            rd_addr <= '0;
            acc_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        rd_addr <= '0;
                        acc_q   <= '0;
                    end
                end
                MUL: begin
                    prod_q <= mult_p;
                end
                ACC: begin
                    acc_q <= add_s;
                    if (last) begin
                        result <= add_s;
                    end else begin
                        idx_q   <= idx_q + ADDR_W'(1);
                        rd_addr <= idx_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Shared units see zeros when not in use so they do not toggle.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE) && !clear;
        mult_a = 16'h0000;
        mult_b = 16'h0000;
        add_a  = 16'h0000;
        add_b  = 16'h0000;
        if (state_q == MUL) begin
            mult_a = a_data;
            mult_b = b_data;
        end
        if (state_q == ACC) begin
            add_a = acc_q;
            add_b = prod_q;
        end
    end

endmodule
